// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache memory-side controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cache_pkg;

    localparam int LINE_W  = 128;
    localparam int WORD_W  = 32;
    localparam int LADDR_W = 23;
    localparam int PADDR_W = LADDR_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WB,
        FILL_REQ,
        FILL_WAIT,
        FILL_WR,
        REPLAY
    } state_t;

    // Processor word address.
    // The offset field selects the word within the line.
    // The line field holds {tag, index}.
    typedef struct packed {
        logic [LADDR_W-1:0] line;
        logic [1:0]         offset;
    } paddr_t;

    // Set index: the low idx_w bits of the line address.
    function automatic logic [LADDR_W-1:0] line_index(input logic [LADDR_W-1:0] line,
                                                      input int idx_w);
        logic [LADDR_W-1:0] mask;
        mask = (LADDR_W'(1) << idx_w) - LADDR_W'(1);
        return line & mask;
    endfunction

    // Tag: the line address bits above the index.
    function automatic logic [LADDR_W-1:0] line_tag(input logic [LADDR_W-1:0] line,
                                                    input int idx_w);
        return line >> idx_w;
    endfunction

endpackage

// File: rtl/cache_word_sel.sv
// Word select: picks one 32-bit word from a 128-bit line and decodes the offset to a one-hot word enable.
// Latency: combinational.
// Backpressure: none.
// Ports: line (set line in), offset (word offset in), word (selected word out), word_en (one-hot lane out).
module cache_word_sel
    import cache_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [1:0]        offset,
    output logic [WORD_W-1:0] word,
    output logic [3:0]        word_en
);

    always_comb begin
        word    = line[offset*WORD_W +: WORD_W];
        word_en = 4'b0001 << offset;
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side controller for one cache_set.
//   Serves read and write hits from the set.
//   Writes back dirty victims, refills the line, then replays the access.
// Latency: a hit completes one cycle after the request is sampled.
//   A clean miss takes 4 cycles plus the memory latency.
//   A dirty miss adds the write-back handshake.
// Backpressure: p_waitrequest is high except in the completing cycle.
//   Memory requests are held until m_waitrequest is low.
// Ports:
//   p_*      processor request/response.
//   entry, o_tag, writedata, byte_en, word_en, write, read_miss
//            drive the set.
//   readdata, wb_addr, hit, modify, miss, valid
//            set status.
//   m_*      external memory bus.
module cache_mem_ctrl
    import cache_pkg::*;
#(
    parameter int cache_entry = 14
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PADDR_W-1:0]             p_addr,
    input  logic                           p_read,
    input  logic                           p_write,
    input  logic [WORD_W-1:0]              p_writedata,
    input  logic [3:0]                     p_byte_en,
    output logic [WORD_W-1:0]              p_readdata,
    output logic                           p_waitrequest,
    output logic [cache_entry-1:0]         entry,
    output logic [LADDR_W-cache_entry-1:0] o_tag,
    output logic [LINE_W-1:0]              writedata,
    output logic [3:0]                     byte_en,
    output logic [3:0]                     word_en,
    output logic                           write,
    output logic                           read_miss,
    input  logic [LINE_W-1:0]              readdata,
    input  logic [LADDR_W-1:0]             wb_addr,
    input  logic                           hit,
    input  logic                           modify,
    input  logic                           miss,
    input  logic                           valid,
    output logic [LADDR_W-1:0]             m_addr,
    output logic                           m_read,
    output logic                           m_write,
    output logic [LINE_W-1:0]              m_writedata,
    input  logic [LINE_W-1:0]              m_readdata,
    input  logic                           m_readdatavalid,
    input  logic                           m_waitrequest
);

    localparam int TAG_W = LADDR_W - cache_entry;

    state_t             state_q,  state_d;
    paddr_t             addr_q,   addr_d;
    logic               op_wr_q,  op_wr_d;
    logic [WORD_W-1:0]  wdata_q,  wdata_d;
    logic [3:0]         be_q,     be_d;
    logic [LINE_W-1:0]  wb_q,     wb_d;
    logic [LADDR_W-1:0] wbaddr_q, wbaddr_d;
    logic [LINE_W-1:0]  fill_q,   fill_d;

    paddr_t             req_p;
    logic [WORD_W-1:0]  sel_word;
    logic [3:0]         sel_en;

    assign req_p = p_addr;

    // In IDLE the set is addressed straight from the processor port.
    // This lets the tag lookup overlap the capture cycle.
    // Everywhere else the captured request drives the set.
    assign entry = (state_q == IDLE) ? cache_entry'(line_index(req_p.line, cache_entry))
                                     : cache_entry'(line_index(addr_q.line, cache_entry));
    assign o_tag = (state_q == IDLE) ? TAG_W'(line_tag(req_p.line, cache_entry))
                                     : TAG_W'(line_tag(addr_q.line, cache_entry));

    cache_word_sel u_word_sel (
        .line    (readdata),
        .offset  (addr_q.offset),
        .word    (sel_word),
        .word_en (sel_en)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        op_wr_d       = op_wr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        wb_d          = wb_q;
        wbaddr_d      = wbaddr_q;
        fill_d        = fill_q;

        p_readdata    = sel_word;
        p_waitrequest = 1'b1;
        writedata     = {4{wdata_q}};
        word_en       = sel_en;
        byte_en       = be_q;
        write         = 1'b0;
        read_miss     = 1'b0;
        m_addr        = addr_q.line;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = wb_q;

        case (state_q)
            IDLE: begin
                if (p_read || p_write) begin
                    addr_d  = req_p;
                    op_wr_d = p_write;  // a simultaneous read+write is taken as a write
                    wdata_d = p_writedata;
                    be_d    = p_byte_en;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    p_waitrequest = 1'b0;
                    write         = op_wr_q;
                    state_d       = IDLE;
                end else if (miss && valid && modify) begin
                    // Dirty victim: snapshot it now.
                    // The refill will overwrite the line in the set.
                    wb_d     = readdata;
                    wbaddr_d = wb_addr;
                    state_d  = WB;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            WB: begin
                m_write = 1'b1;
                m_addr  = wbaddr_q;
                if (!m_waitrequest) begin
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                m_read = 1'b1;
                if (!m_waitrequest) begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (m_readdatavalid) begin
                    fill_d  = m_readdata;
                    state_d = FILL_WR;
                end
            end
            FILL_WR: begin
                write     = 1'b1;
                read_miss = 1'b1;
                writedata = fill_q;
                word_en   = 4'hF;
                byte_en   = 4'hF;
                state_d   = REPLAY;
            end
            REPLAY: begin
                // The set reads the entry at this edge.
                // COMPARE then sees the freshly written tag and hits.
                state_d = COMPARE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            op_wr_q  <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            wb_q     <= '0;
            wbaddr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            op_wr_q  <= op_wr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            wb_q     <= wb_d;
            wbaddr_q <= wbaddr_d;
            fill_q   <= fill_d;
        end
    end

endmodule
